i2c_target_regfile: RTL

- I2C target (responder) with a 7-bit address and an internal byte register file. It is the far end of the board's I2C master logic.
- Lets the master logic be exercised on-chip without the external EEPROM. Emulates 24LC02B-style addressing: byte write, current/random read, sequential read with auto-increment.
- Runs entirely on CLOCK_50; SCL/SDA are oversampled, never used as clocks.
- SDA is open-drain: the block only ever pulls it low.

---
 rtl/i2c_pkg.sv | 16 +
 rtl/i2c_line_filter.sv | 61 ++++++
 rtl/i2c_target_regfile.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared FSM state encodings and bus-level constants for the I2C target register file.
package i2c_pkg;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ADDR  = 3'd1;
   localparam logic [2:0] S_ACK_A = 3'd2;
   localparam logic [2:0] S_PTR   = 3'd3;
   localparam logic [2:0] S_ACK_W = 3'd4;
   localparam logic [2:0] S_WDATA = 3'd5;
   localparam logic [2:0] S_RDATA = 3'd6;
   localparam logic [2:0] S_RACK  = 3'd7;

   localparam logic I2C_RW_READ = 1'b1;
   localparam logic I2C_ACK     = 1'b0;

endpackage

// File: rtl/i2c_line_filter.sv
// Synchronizes one raw I2C line, accepts a new level only after FILT_LEN stable cycles,
// and reports one-cycle rise/fall pulses aligned with the accepted level change.
module i2c_line_filter #(
   parameter int unsigned FILT_LEN = 3
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic line_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int unsigned CW = $clog2(FILT_LEN + 1);

   logic          meta_q, sync_q;
   logic          level_q, level_d;
   logic          rise_q, rise_d;
   logic          fall_q, fall_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Count consecutive cycles the synchronized line disagrees with the accepted level.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (sync_q != level_q) begin
         if (cnt_q == CW'(FILT_LEN - 1)) begin
            level_d = sync_q;
            rise_d  = sync_q;
            fall_d  = ~sync_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         meta_q  <= 1'b1;
         sync_q  <= 1'b1;
         level_q <= 1'b1;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         meta_q  <= line_i;
         sync_q  <= meta_q;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level_o = level_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target with a byte register file: 24LC02B-style pointer write, byte write,
// current/random read and auto-incrementing sequential access, all oversampled on CLOCK_50.
module i2c_target_regfile
   import i2c_pkg::*;
#(
   parameter logic [6:0]  DEV_ADDR = 7'h50,
   parameter int unsigned MEM_AW   = 4,
   parameter int unsigned FILT_LEN = 3
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic              scl_in,
   input  logic              sda_in,
   output logic              sda_oe,
   output logic              wr_strobe,
   output logic [MEM_AW-1:0] wr_addr,
   output logic [7:0]        wr_data,
   input  logic [MEM_AW-1:0] dbg_addr,
   output logic [7:0]        dbg_data,
   output logic              busy
);

   localparam int unsigned DEPTH = 2 ** MEM_AW;

   logic scl_lvl, scl_rise, scl_fall;
   logic sda_lvl, sda_rise, sda_fall;

   i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
      .clk_i(CLOCK_50), .reset_i(reset), .line_i(scl_in),
      .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
   );

   i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
      .clk_i(CLOCK_50), .reset_i(reset), .line_i(sda_in),
      .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
   );

   logic [7:0]        mem_q [DEPTH];
   logic [2:0]        state_q, state_d;
   logic [2:0]        bitcnt_q, bitcnt_d;
   logic [7:0]        shift_q, shift_d;
   logic [MEM_AW-1:0] ptr_q, ptr_d;
   logic              sda_oe_q, sda_oe_d;
   logic              busy_q, busy_d;
   logic              rw_q, rw_d;
   logic              data_ack_q, data_ack_d;
   logic              rack_ok_q, rack_ok_d;
   logic              wr_strobe_q, wr_strobe_d;
   logic [MEM_AW-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]        wr_data_q, wr_data_d;
   logic              commit_c;
   logic [7:0]        byte_c;
   logic              start_c, stop_c;

   assign start_c = sda_fall & scl_lvl;
   assign stop_c  = sda_rise & scl_lvl;
   assign byte_c  = {shift_q[6:0], sda_lvl};

   // ACK phases use sda_oe_q itself to tell the 8th falling edge (assert) from the 9th (release).
   always_comb begin
      state_d     = state_q;
      bitcnt_d    = bitcnt_q;
      shift_d     = shift_q;
      ptr_d       = ptr_q;
      sda_oe_d    = sda_oe_q;
      busy_d      = busy_q;
      rw_d        = rw_q;
      data_ack_d  = data_ack_q;
      rack_ok_d   = rack_ok_q;
      wr_strobe_d = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      commit_c    = 1'b0;

      if (start_c) begin
         state_d  = S_ADDR;
         bitcnt_d = '0;
         sda_oe_d = 1'b0;
      end else if (stop_c) begin
         state_d  = S_IDLE;
         bitcnt_d = '0;
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
      end else begin
         case (state_q)
            S_ADDR, S_PTR, S_WDATA: begin
               if (scl_rise) begin
                  shift_d  = byte_c;
                  bitcnt_d = bitcnt_q + 3'd1;
                  if (bitcnt_q == 3'd7) begin
                     bitcnt_d = '0;
                     if (state_q == S_ADDR) begin
                        if (byte_c[7:1] == DEV_ADDR) begin
                           state_d = S_ACK_A;
                           busy_d  = 1'b1;
                           rw_d    = byte_c[0];
                        end else begin
                           state_d = S_IDLE;
                        end
                     end else begin
                        if (state_q == S_PTR) ptr_d = byte_c[MEM_AW-1:0];
                        data_ack_d = (state_q == S_WDATA);
                        state_d    = S_ACK_W;
                     end
                  end
               end
            end
            S_ACK_A: begin
               if (scl_fall) begin
                  if (!sda_oe_q) begin
                     sda_oe_d = 1'b1;
                  end else if (rw_q == I2C_RW_READ) begin
                     state_d  = S_RDATA;
                     shift_d  = mem_q[ptr_q];
                     sda_oe_d = ~mem_q[ptr_q][7];
                     bitcnt_d = '0;
                  end else begin
                     state_d  = S_PTR;
                     sda_oe_d = 1'b0;
                     bitcnt_d = '0;
                  end
               end
            end
            S_ACK_W: begin
               if (scl_rise && data_ack_q && sda_oe_q) begin
                  commit_c    = 1'b1;
                  wr_strobe_d = 1'b1;
                  wr_addr_d   = ptr_q;
                  wr_data_d   = shift_q;
                  ptr_d       = ptr_q + MEM_AW'(1);
               end
               if (scl_fall) begin
                  if (!sda_oe_q) begin
                     sda_oe_d = 1'b1;
                  end else begin
                     sda_oe_d = 1'b0;
                     state_d  = S_WDATA;
                     bitcnt_d = '0;
                  end
               end
            end
            S_RDATA: begin
               if (scl_fall) begin
                  if (bitcnt_q == 3'd7) begin
                     sda_oe_d  = 1'b0;
                     state_d   = S_RACK;
                     rack_ok_d = 1'b0;
                     bitcnt_d  = '0;
                  end else begin
                     shift_d  = {shift_q[6:0], 1'b0};
                     sda_oe_d = ~shift_q[6];
                     bitcnt_d = bitcnt_q + 3'd1;
                  end
               end
            end
            S_RACK: begin
               if (scl_rise) begin
                  ptr_d = ptr_q + MEM_AW'(1);
                  if (sda_lvl == I2C_ACK) rack_ok_d = 1'b1;
                  else                    state_d   = S_IDLE;
               end
               if (scl_fall && rack_ok_q) begin
                  state_d  = S_RDATA;
                  shift_d  = mem_q[ptr_q];
                  sda_oe_d = ~mem_q[ptr_q][7];
                  bitcnt_d = '0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q     <= S_IDLE;
         bitcnt_q    <= '0;
         shift_q     <= '0;
         ptr_q       <= '0;
         sda_oe_q    <= 1'b0;
         busy_q      <= 1'b0;
         rw_q        <= 1'b0;
         data_ack_q  <= 1'b0;
         rack_ok_q   <= 1'b0;
         wr_strobe_q <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         bitcnt_q    <= bitcnt_d;
         shift_q     <= shift_d;
         ptr_q       <= ptr_d;
         sda_oe_q    <= sda_oe_d;
         busy_q      <= busy_d;
         rw_q        <= rw_d;
         data_ack_q  <= data_ack_d;
         rack_ok_q   <= rack_ok_d;
         wr_strobe_q <= wr_strobe_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
      end
   end

   // Register file keeps its contents through reset.
   always_ff @(posedge CLOCK_50) begin
      if (commit_c && !reset) mem_q[ptr_q] <= shift_q;
   end

   assign dbg_data  = mem_q[dbg_addr];
   assign sda_oe    = sda_oe_q;
   assign busy      = busy_q;
   assign wr_strobe = wr_strobe_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;

endmodule
